muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Takes rs/rt operand values (doutA/doutB) with a decoded op, and computes MULT/MULTU/DIV/DIVU into HI/LO over multiple cycles.
- Also services MTHI/MTLO.
- Drives `busy` so the hazard logic stalls any muldiv op or MFHI/MFLO until results are architecturally valid.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation codes driven by the decoder; 6 and 7 are reserved and treated as no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy codes 0..3, so bit 2 clear marks an iterative op.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Signed variants are the even codes among the iterative ops.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2*WIDTH accumulator.
// Multiply: add the multiplicand into the upper half when the multiplier bit is set,
//           then shift the whole accumulator right (LSB of multiplier first).
// Divide:   shift the next dividend bit into the partial remainder (upper half),
//           try to subtract the divisor, restore on borrow; quotient bits
//           shift into the lower half from the right.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_opnd,
  input  logic                 i_bit,
  output logic [2*WIDTH-1:0]   o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_part;
  logic [WIDTH:0] w_diff;

  // Both candidate results are formed every cycle; the op selects which one lands.
  always_comb begin
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_bit ? {1'b0, i_opnd} : '0);
    w_part = {i_acc[2*WIDTH-1:WIDTH], i_bit};
    w_diff = w_part - {1'b0, i_opnd};
    o_acc  = '0;
    if (i_is_div) begin
      // Partial remainder is always below 2*divisor, so bit WIDTH of the difference is the borrow.
      if (!w_diff[WIDTH]) o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else                o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO for the EX stage.
// State | meaning
// IDLE  | waiting for an op; MTHI/MTLO complete here in one edge
// CALC  | WIDTH radix-2 iterations on operand magnitudes
// FIX   | sign correction and HI/LO commit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              flush,
  output logic              busy,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_opa;
  logic [WIDTH-1:0]    r_opb;
  logic [2*WIDTH-1:0]  r_acc;
  logic                r_is_div;
  logic                r_dz;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;

  logic                w_go;
  logic                w_arith;
  logic                w_signed;
  logic                w_dz;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic                w_step_bit;
  logic [WIDTH-1:0]    w_step_opnd;
  logic [2*WIDTH-1:0]  w_step_acc;
  logic [2*WIDTH-1:0]  w_prod_neg;

  assign busy = (r_state != ST_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // A start is only honoured in IDLE and never alongside a flush.
  assign w_go     = start && !flush && (r_state == ST_IDLE);
  assign w_arith  = md_is_arith(op);
  assign w_signed = md_is_signed(op);
  assign w_dz     = op[1] && (b == '0);
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply walks the multiplier LSB-up; divide walks the dividend MSB-down (WIDTH-1-cnt == ~cnt).
  assign w_step_bit  = r_is_div ? r_opa[~r_cnt] : r_opb[r_cnt];
  assign w_step_opnd = r_is_div ? r_opb : r_opa;
  assign w_prod_neg  = ~r_acc + 1'b1;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (w_step_opnd),
    .i_bit    (w_step_bit),
    .o_acc    (w_step_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode; divide-by-zero bypasses CALC entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go && w_arith) w_state_nxt = w_dz ? ST_FIX : ST_CALC;
      ST_CALC: begin
        if (flush)                             w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))   w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and HI/LO update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            if (op == MD_MTHI) r_hi <= a;
            if (op == MD_MTLO) r_lo <= a;
            if (w_arith) begin
              // Divide-by-zero keeps the raw dividend since it is committed to HI unchanged.
              r_opa    <= w_dz ? a : w_abs_a;
              r_opb    <= w_abs_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_is_div <= op[1];
              r_dz     <= w_dz;
              r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= w_signed && a[WIDTH-1];
            end
          end
        end
        ST_CALC: begin
          if (!flush) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            if (r_dz) begin
              r_hi <= r_opa;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_lo <= r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
              r_hi <= r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
            end else begin
              {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against
// a 64-bit arithmetic model, and hand-written flush/reset/busy-start sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    sa  = longint'($signed(ma));
    sbv = longint'($signed(mb));
    e.cyc = 33;
    e.hi  = '0;
    e.lo  = '0;
    case (mop)
      3'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'b0, ma} * {32'b0, mb}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (mb == 0) begin
          e.hi = ma; e.lo = 32'hFFFF_FFFF; e.cyc = 1;
        end else if (mop == 3'd2) begin
          e.lo = 32'(sa / sbv); e.hi = 32'(sa % sbv);
        end else begin
          e.lo = ma / mb; e.hi = ma % mb;
        end
      end
    endcase
    return e;
  endfunction

  // Drive one iterative op, push its expectation, then wait out busy and compare.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input exp_t e);
    exp_t got;
    int   n;
    sb_q.push_back(e);
    start = 1'b1; op = o; a = va; b = vb;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    got = sb_q.pop_front();
    check({name, " busy_cycles"}, 64'(n), 64'(got.cyc));
    check({name, " hi"}, 64'(hi), 64'(got.hi));
    check({name, " lo"}, 64'(lo), 64'(got.lo));
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb, sv_hi, sv_lo;
    logic [2:0]  rop;
    int          n;

    vecs[0] = '{op: 3'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, cyc: 33};
    vecs[1] = '{op: 3'd0, a: 32'hFFFF_FFFD, b: 32'd5,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1, cyc: 33};
    vecs[2] = '{op: 3'd2, a: 32'hFFFF_FFF9, b: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, cyc: 33};
    vecs[3] = '{op: 3'd3, a: 32'd100,       b: 32'd0,         hi: 32'd100,       lo: 32'hFFFF_FFFF, cyc: 1};
    vecs[4] = '{op: 3'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000, cyc: 33};
    vecs[5] = '{op: 3'd0, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0000_0000, cyc: 33};
    vecs[6] = '{op: 3'd2, a: 32'd7,         b: 32'hFFFF_FFFE, hi: 32'h0000_0001, lo: 32'hFFFF_FFFD, cyc: 33};

    // Reset state.
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    rst = 1'b1;
    step();

    // Directed table, issued back-to-back on the cycle busy falls.
    for (int i = 0; i < 7; i++) begin
      e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.cyc = vecs[i].cyc;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    // Random ops against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = (i == 3) ? 32'd0 : $urandom();
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // MTHI then MTLO on consecutive cycles.
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    step();
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    step();
    start = 1'b0;
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);

    // Reserved op codes are no-ops.
    start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'd3;
    step();
    op = 3'd7;
    step();
    start = 1'b0;
    check("rsvd busy", 64'(busy), 64'd0);
    check("rsvd hi", 64'(hi), 64'h1234_5678);
    check("rsvd lo", 64'(lo), 64'h9ABC_DEF0);

    // Starts issued while busy are ignored.
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    step();
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    step();
    op = 3'd0; a = 32'd100; b = 32'd100;
    step();
    start = 1'b0;
    check("busy-start hi during op", 64'(hi), 64'h1234_5678);
    n = 2;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("busy-start cycles", 64'(n), 64'd33);
    check("busy-start hi", 64'(hi), 64'd0);
    check("busy-start lo", 64'(lo), 64'd12);

    // Preload, then flush mid-CALC.
    start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
    step();
    op = 3'd5; a = 32'h0000_5555;
    step();
    op = 3'd1; a = 32'd7; b = 32'd9;
    step();
    start = 1'b0;
    repeat (9) step();
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    repeat (40) step();
    check("flush hi", 64'(hi), 64'hAAAA_0000);
    check("flush lo", 64'(lo), 64'h0000_5555);

    // Flush and start together in IDLE.
    flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'h0BAD_0BAD;
    step();
    op = 3'd1; a = 32'd2; b = 32'd2;
    step();
    flush = 1'b0; start = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    check("flush+start hi", 64'(hi), 64'hAAAA_0000);
    check("flush+start lo", 64'(lo), 64'h0000_5555);

    // Asynchronous reset between edges mid-CALC.
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd3;
    step();
    start = 1'b0;
    repeat (5) step();
    sv_hi = hi; sv_lo = lo;
    check("pre-reset busy", 64'(busy), 64'd1);
    check("pre-reset lo", 64'(sv_lo), 64'h0000_5555);
    #3 rst = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    #2 rst = 1'b1;
    step();
    check("post rst busy", 64'(busy), 64'd0);
    e.hi = 32'd6; e.lo = 32'd142; e.cyc = 33;
    run_op("divu 1000/7", 3'd3, 32'd1000, 32'd7, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
